// File: rtl/cv32e40x_rvfi_pkg.sv
// Shared types for the RVFI data-transaction scheduler: aligned OBI request
// payload and the per-instruction group reported on retirement.
package cv32e40x_rvfi_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } obi_data_req_t;

   // trans[1] is only meaningful when cnt == 2 (misaligned split)
   typedef struct packed {
      obi_data_req_t [1:0] trans;
      logic [1:0]          cnt;
   } rvfi_data_grp_t;

   typedef enum logic {
      GRP_IDLE = 1'b0,
      GRP_OPEN = 1'b1
   } grp_state_e;

   function automatic rvfi_data_grp_t grp_make(input obi_data_req_t t0,
                                               input obi_data_req_t t1,
                                               input logic [1:0]    cnt);
      rvfi_data_grp_t g;
      g.trans[0] = t0;
      g.trans[1] = t1;
      g.cnt      = cnt;
      return g;
   endfunction

endpackage

// File: rtl/cv32e40x_rvfi_grp_fifo.sv
// In-order queue of per-instruction transaction groups with flush.
module cv32e40x_rvfi_grp_fifo
   import cv32e40x_rvfi_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push_i,
   input  rvfi_data_grp_t push_data_i,
   input  logic           pop_i,
   input  logic           flush_i,
   output rvfi_data_grp_t head_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   rvfi_data_grp_t   mem_q [DEPTH];
   rvfi_data_grp_t   mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok;
   logic             push_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // A full queue still accepts a push when the head leaves in the same cycle
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (flush_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = '0;
         end
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cv32e40x_rvfi_data_sched.sv
// Groups aligned LSU transactions per instruction and releases each group to
// RVFI on the retirement cycle of its load/store.
module cv32e40x_rvfi_data_sched
   import cv32e40x_rvfi_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  obi_data_req_t  trans_i,
   input  logic           trans_valid_i,
   input  logic           trans_last_i,
   input  logic           kill_i,
   input  logic           wb_retire_i,
   output logic           rvfi_valid_o,
   output rvfi_data_grp_t rvfi_trans_o,
   output logic           full_o,
   output logic           err_o
);

   grp_state_e     state_q, state_d;
   obi_data_req_t  stage_q, stage_d;
   logic           rvfi_valid_q, rvfi_valid_d;
   rvfi_data_grp_t rvfi_trans_q, rvfi_trans_d;
   logic           err_q, err_d;

   logic           commit_c;
   rvfi_data_grp_t commit_grp_c;
   logic           bad_split_c;
   logic           fifo_full;
   logic           fifo_empty;
   rvfi_data_grp_t fifo_head;
   logic           overflow_c;
   logic           underflow_c;

   cv32e40x_rvfi_grp_fifo #(
      .DEPTH (DEPTH)
   ) u_grp_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (commit_c),
      .push_data_i (commit_grp_c),
      .pop_i       (wb_retire_i),
      .flush_i     (kill_i),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Split-grouping FSM; a push coinciding with a kill belongs to a flushed instruction
   always_comb begin
      state_d      = state_q;
      stage_d      = stage_q;
      commit_c     = 1'b0;
      commit_grp_c = '0;
      bad_split_c  = 1'b0;
      if (trans_valid_i && !kill_i) begin
         unique case (state_q)
            GRP_IDLE: begin
               if (trans_last_i) begin
                  commit_c     = 1'b1;
                  commit_grp_c = grp_make(trans_i, '0, 2'd1);
               end else begin
                  stage_d = trans_i;
                  state_d = GRP_OPEN;
               end
            end
            GRP_OPEN: begin
               if (trans_last_i) begin
                  commit_c     = 1'b1;
                  commit_grp_c = grp_make(stage_q, trans_i, 2'd2);
                  stage_d      = '0;
                  state_d      = GRP_IDLE;
               end else begin
                  bad_split_c = 1'b1;
                  stage_d     = trans_i;
               end
            end
            default: begin
               state_d = GRP_IDLE;
            end
         endcase
      end
      if (kill_i) begin
         stage_d = '0;
         state_d = GRP_IDLE;
      end
   end

   // Underflow sees only registered occupancy, so a same-cycle commit is never bypassed
   assign underflow_c = wb_retire_i && fifo_empty;
   assign overflow_c  = commit_c && fifo_full && !wb_retire_i;

   always_comb begin
      rvfi_valid_d = wb_retire_i;
      rvfi_trans_d = rvfi_trans_q;
      if (wb_retire_i) begin
         rvfi_trans_d = fifo_empty ? '0 : fifo_head;
      end
      err_d = err_q || bad_split_c || underflow_c || overflow_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= GRP_IDLE;
         stage_q      <= '0;
         rvfi_valid_q <= 1'b0;
         rvfi_trans_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         stage_q      <= stage_d;
         rvfi_valid_q <= rvfi_valid_d;
         rvfi_trans_q <= rvfi_trans_d;
         err_q        <= err_d;
      end
   end

   assign rvfi_valid_o = rvfi_valid_q;
   assign rvfi_trans_o = rvfi_trans_q;
   assign full_o       = fifo_full;
   assign err_o        = err_q;

endmodule

// File: tb/tb_cv32e40x_rvfi_data_sched.sv
// Scoreboard bench for the RVFI data scheduler: a behavioural queue model
// predicts each retired group, err_o and full_o cycle by cycle.
module tb_cv32e40x_rvfi_data_sched;
   import cv32e40x_rvfi_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   obi_data_req_t  trans_i;
   logic           trans_valid_i;
   logic           trans_last_i;
   logic           kill_i;
   logic           wb_retire_i;
   logic           rvfi_valid_o;
   rvfi_data_grp_t rvfi_trans_o;
   logic           full_o;
   logic           err_o;

   int n_vec  = 0;
   int n_miss = 0;

   rvfi_data_grp_t mdl_q[$];
   rvfi_data_grp_t exp_q[$];
   logic           m_open;
   obi_data_req_t  m_stage;
   logic           m_err;
   rvfi_data_grp_t last_out;

   always #5 clk = ~clk;

   cv32e40x_rvfi_data_sched #(
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .trans_i       (trans_i),
      .trans_valid_i (trans_valid_i),
      .trans_last_i  (trans_last_i),
      .kill_i        (kill_i),
      .wb_retire_i   (wb_retire_i),
      .rvfi_valid_o  (rvfi_valid_o),
      .rvfi_trans_o  (rvfi_trans_o),
      .full_o        (full_o),
      .err_o         (err_o)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic obi_data_req_t mk(input logic [31:0] addr);
      obi_data_req_t t;
      t.addr  = addr;
      t.we    = addr[2];
      t.be    = 4'hF;
      t.wdata = addr ^ 32'hA5A5_0000;
      return t;
   endfunction

   function automatic rvfi_data_grp_t grp(input obi_data_req_t t0, input obi_data_req_t t1,
                                          input logic [1:0] cnt);
      rvfi_data_grp_t g;
      g.trans[0] = t0;
      g.trans[1] = t1;
      g.cnt      = cnt;
      return g;
   endfunction

   // Model: the retiring instruction is older, so pop precedes kill and commit
   task automatic model(input logic v, input logic last, input obi_data_req_t t,
                        input logic kill, input logic ret);
      rvfi_data_grp_t e;
      rvfi_data_grp_t c;
      logic           do_commit;
      do_commit = 1'b0;
      c         = '0;
      if (ret) begin
         if (mdl_q.size() > 0) begin
            e = mdl_q.pop_front();
         end else begin
            e     = '0;
            m_err = 1'b1;
         end
         exp_q.push_back(e);
      end
      if (kill) begin
         mdl_q.delete();
         m_open  = 1'b0;
         m_stage = '0;
      end else if (v) begin
         if (!m_open) begin
            if (last) begin
               do_commit = 1'b1;
               c         = grp(t, '0, 2'd1);
            end else begin
               m_stage = t;
               m_open  = 1'b1;
            end
         end else if (last) begin
            do_commit = 1'b1;
            c         = grp(m_stage, t, 2'd2);
            m_open    = 1'b0;
         end else begin
            m_err   = 1'b1;
            m_stage = t;
         end
      end
      if (do_commit) begin
         if (mdl_q.size() == int'(DEPTH)) m_err = 1'b1;
         else mdl_q.push_back(c);
      end
   endtask

   task automatic step(input string tag, input logic v, input logic last,
                       input logic [31:0] addr, input logic kill, input logic ret);
      rvfi_data_grp_t e;
      trans_valid_i = v;
      trans_last_i  = last;
      trans_i       = mk(addr);
      kill_i        = kill;
      wb_retire_i   = ret;
      model(v, last, mk(addr), kill, ret);
      @(posedge clk);
      #1;
      trans_valid_i = 1'b0;
      trans_last_i  = 1'b0;
      kill_i        = 1'b0;
      wb_retire_i   = 1'b0;
      check({tag, ".valid"}, 256'(rvfi_valid_o), 256'(ret));
      if (rvfi_valid_o) begin
         if (exp_q.size() == 0) begin
            check({tag, ".spurious"}, 256'(rvfi_valid_o), 256'(1'b0));
         end else begin
            e = exp_q.pop_front();
            check({tag, ".trans"}, 256'(rvfi_trans_o), 256'(e));
            last_out = e;
         end
      end else begin
         check({tag, ".hold"}, 256'(rvfi_trans_o), 256'(last_out));
      end
      check({tag, ".full"}, 256'(full_o), 256'(mdl_q.size() == int'(DEPTH)));
      check({tag, ".err"}, 256'(err_o), 256'(m_err));
   endtask

   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, ".rst_valid"}, 256'(rvfi_valid_o), 256'(1'b0));
      check({tag, ".rst_trans"}, 256'(rvfi_trans_o), 256'(0));
      check({tag, ".rst_full"}, 256'(full_o), 256'(1'b0));
      check({tag, ".rst_err"}, 256'(err_o), 256'(1'b0));
      mdl_q.delete();
      exp_q.delete();
      m_open   = 1'b0;
      m_stage  = '0;
      m_err    = 1'b0;
      last_out = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      trans_i       = '0;
      trans_valid_i = 1'b0;
      trans_last_i  = 1'b0;
      kill_i        = 1'b0;
      wb_retire_i   = 1'b0;
      do_reset("init");

      // single store, retire two cycles after the commit
      step("st_push", 1'b1, 1'b1, 32'h104, 1'b0, 1'b0);
      step("st_gap", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step("st_ret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("st_cnt", 256'(rvfi_trans_o.cnt), 256'(2'd1));
      check("st_addr0", 256'(rvfi_trans_o.trans[0].addr), 256'(32'h104));
      step("st_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

      // misaligned split load
      step("sp_lo", 1'b1, 1'b0, 32'h1FE, 1'b0, 1'b0);
      step("sp_hi", 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
      step("sp_ret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("sp_cnt", 256'(rvfi_trans_o.cnt), 256'(2'd2));
      check("sp_addr0", 256'(rvfi_trans_o.trans[0].addr), 256'(32'h1FE));
      check("sp_addr1", 256'(rvfi_trans_o.trans[1].addr), 256'(32'h200));

      // fill, commit+pop while full, then overflow, then drain in order
      for (int i = 0; i < int'(DEPTH); i++) begin
         step("fill", 1'b1, 1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
      end
      check("fill_full", 256'(full_o), 256'(1'b1));
      check("fill_err", 256'(err_o), 256'(1'b0));
      step("full_cp", 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1);
      check("full_cp_err", 256'(err_o), 256'(1'b0));
      step("ovf", 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0);
      check("ovf_err", 256'(err_o), 256'(1'b1));
      for (int i = 0; i < int'(DEPTH); i++) begin
         step("drain", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      end

      // pointer wrap-around with back-to-back commit/retire pairs
      do_reset("wrap");
      for (int i = 0; i < 10; i++) begin
         step("wrap_push", 1'b1, 1'b1, 32'h4000 + 32'(i * 16), 1'b0, 1'b0);
         step("wrap_ret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
         check("wrap_addr", 256'(rvfi_trans_o.trans[0].addr), 256'(32'h4000 + 32'(i * 16)));
      end
      check("wrap_err", 256'(err_o), 256'(1'b0));

      // kill with concurrent retire: head leaves, second entry is discarded
      step("kill_a", 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0);
      step("kill_b", 1'b1, 1'b1, 32'h5004, 1'b0, 1'b0);
      step("kill_ret", 1'b1, 1'b1, 32'h5008, 1'b1, 1'b1);
      check("kill_addr", 256'(rvfi_trans_o.trans[0].addr), 256'(32'h5000));
      step("kill_uf", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("kill_uf_cnt", 256'(rvfi_trans_o.cnt), 256'(2'd0));
      check("kill_uf_err", 256'(err_o), 256'(1'b1));

      // underflow with a same-cycle commit keeps the committed entry
      step("uf_push", 1'b1, 1'b1, 32'h5100, 1'b0, 1'b1);
      step("uf_ret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("uf_kept", 256'(rvfi_trans_o.trans[0].addr), 256'(32'h5100));

      // bad split: two non-last pushes in a row
      do_reset("bad");
      step("bad_a", 1'b1, 1'b0, 32'h6000, 1'b0, 1'b0);
      step("bad_b", 1'b1, 1'b0, 32'h6010, 1'b0, 1'b0);
      step("bad_c", 1'b1, 1'b1, 32'h6014, 1'b0, 1'b0);
      step("bad_ret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("bad_addr0", 256'(rvfi_trans_o.trans[0].addr), 256'(32'h6010));

      // reset while OPEN with two entries queued
      do_reset("ro_pre");
      step("ro_a", 1'b1, 1'b1, 32'h7000, 1'b0, 1'b0);
      step("ro_b", 1'b1, 1'b1, 32'h7004, 1'b0, 1'b1);
      step("ro_c", 1'b1, 1'b1, 32'h7008, 1'b0, 1'b0);
      step("ro_open", 1'b1, 1'b0, 32'h700C, 1'b0, 1'b0);
      do_reset("ro");
      step("ro_push", 1'b1, 1'b1, 32'h7100, 1'b0, 1'b0);
      step("ro_ret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("ro_cnt", 256'(rvfi_trans_o.cnt), 256'(2'd1));
      check("ro_addr", 256'(rvfi_trans_o.trans[0].addr), 256'(32'h7100));
      step("ro_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

      check("sb_left", 256'(exp_q.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/cv32e40x_rvfi_data_sched.md
# cv32e40x_rvfi_data_sched

RVFI-side scheduler for aligned data-OBI transactions. It groups the one or two LSU transactions of each load/store instruction, including misaligned splits, into a per-instruction entry and queues those entries in order. It releases the head entry when the owning instruction retires in WB, so RVFI reports memory activity on the retirement cycle. It sits between the aligned LSU transaction stream and the RVFI output registers, and is bhv-only (never synthesized into the core).

## Interface
Parameters:
- DEPTH, 4: number of instruction entries in the queue; power of 2, at least 2.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- trans_i  in  obi_data_req_t  aligned LSU transaction (addr, we, be, wdata, ...).
- trans_valid_i  in  1  trans_i accepted by the write buffer this cycle.
- trans_last_i  in  1  trans_i is the last transaction of its instruction (1 for non-split).
- kill_i  in  1  pipeline flush; discard all unretired entries.
- wb_retire_i  in  1  a load/store instruction retires in WB this cycle.
- rvfi_valid_o  out  1  registered pulse; rvfi_trans_o is valid.
- rvfi_trans_o  out  rvfi_data_grp_t  retired group: trans[0..1] and cnt (1 or 2).
- full_o  out  1  committed entry count == DEPTH.
- err_o  out  1  sticky protocol error (overflow, underflow, or bad split).

## Operation
- Write-side FSM has two states.
  - IDLE: a push with last=1 commits a cnt=1 entry. A push with last=0 stores trans[0] in the staging register and moves to OPEN.
  - OPEN: a push with last=1 writes trans[1], commits a cnt=2 entry and returns to IDLE. A push with last=0 sets err_o and overwrites trans[0].
- Queue: circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of width log2(DEPTH)+1.
- Pop: on wb_retire_i, the head entry is copied into the output register, then rd_ptr increments and count decrements.
- Pop with count==0:
  - err_o is set.
  - rvfi_valid_o still pulses, with cnt=0 and all fields zero.
- Commit while full, with no simultaneous pop: the entry is dropped, err_o is set, and pointers do not change.
- Commit and pop in the same cycle while full: both proceed; count is unchanged.
- kill_i:
  - A same-cycle pop is performed first, because the retiring instruction is older.
  - Then all remaining entries and the staging register are cleared, the FSM returns to IDLE and count goes to 0.
  - A push in the kill cycle is dropped.
- Pop on an empty queue with a same-cycle commit: no bypass. This is an underflow error, and the committed entry is kept.
- err_o is cleared only by rst_n.

## Timing
- Reset values:
  - rvfi_valid_o=0, rvfi_trans_o=0, full_o=0, err_o=0.
  - FSM=IDLE, pointers and count 0.
- Commit → poppable: an entry committed in cycle N can be popped from cycle N+1 onward.
- Pop latency: wb_retire_i in cycle N gives rvfi_valid_o=1 in cycle N+1 for exactly one cycle per retire.
- rvfi_trans_o holds its last value while rvfi_valid_o=0.
- full_o and err_o are combinational from registered state, so they update the cycle after the causing event.
- No ready signal on the push side: full_o is advisory and overflow is only flagged.

## Structure
- rvfi_data_grp_t belongs in cv32e40x_rvfi_pkg: obi_data_req_t trans[2] and logic [1:0] cnt.
- One sub-module: cv32e40x_rvfi_grp_fifo, a DEPTH-entry FIFO of rvfi_data_grp_t with push/pop/flush, count and full/empty.
- The split-grouping FSM, staging register and output register live in the top module.

## Test plan
- Single store at addr 0x104, be=4'b1111, last=1, then wb_retire two cycles later → one cycle after the retire: rvfi_valid_o=1, cnt=1, trans[0].addr=0x104.
- Split load: 0x1FE (last=0), then 0x200 (last=1), then retire → cnt=2, trans[0].addr=0x1FE, trans[1].addr=0x200.
- Four committed entries (DEPTH=4) → full_o=1 and err_o=0.
  - A fifth commit → err_o=1 and the queue is unchanged.
  - A commit concurrent with a pop while full → no error, and output order is preserved.
- Two entries queued, then kill_i concurrent with wb_retire_i → the first entry is output and the second is discarded; a following retire gives cnt=0 and err_o=1.
- Pointer wrap-around: 10 back-to-back commit/retire pairs with DEPTH=4 → outputs come out in order with correct addresses and err_o stays 0.
- Reset asserted while in OPEN with 2 entries queued → all outputs 0 immediately; after release, a cnt=1 transaction retires normally.
